// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results and buffered LSU results onto the
// register file write port. Optional macro WB_PEND_LOOKUP_EN enables the pending-write lookup.
module wb_write_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    input  logic [4:0]                 alu_rd,
    input  logic [31:0]                alu_data,
    output logic                       alu_hold,
    input  logic                       lsu_valid,
    input  logic [4:0]                 lsu_rd,
    input  logic [31:0]                lsu_data,
    output logic                       lsu_ready,
    output logic                       RegWrite,
    output logic [4:0]                 WriteRegister,
    output logic [31:0]                WriteData,
    output logic [$clog2(DEPTH+1)-1:0] buf_count,
    input  logic [4:0]                 pend_query_rd,
    output logic                       pend_hit,
    output logic [31:0]                pend_data
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [DEPTH-1:0] live_q, live_d;
    logic [4:0]       rd_q   [DEPTH];
    logic [4:0]       rd_d   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             reg_write_q, reg_write_d;
    logic [4:0]       wreg_q, wreg_d;
    logic [31:0]      wdata_q, wdata_d;

    logic empty, alu_wr, lsu_acc, push, pop;

    assign empty     = (count_q == '0);
    assign alu_hold  = (starve_q == STARVE_LIM) && !empty;
    assign lsu_ready = (count_q != FULL_CNT);
    assign alu_wr    = alu_valid && !alu_hold && (alu_rd != 5'd0);
    assign lsu_acc   = lsu_valid && lsu_ready;
    // A same-cycle LSU write to the ALU's rd is older than the ALU write, so it is dropped.
    assign push      = lsu_acc && (lsu_rd != 5'd0) && !(alu_wr && (lsu_rd == alu_rd));
    assign pop       = !alu_wr && !empty;

    always_comb begin
        live_d      = live_q;
        rd_d        = rd_q;
        data_d      = data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        starve_d    = starve_q;
        reg_write_d = 1'b0;
        wreg_d      = wreg_q;
        wdata_d     = wdata_q;

        if (alu_wr) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_q[i] == alu_rd) live_d[i] = 1'b0;
            end
            reg_write_d = 1'b1;
            wreg_d      = alu_rd;
            wdata_d     = alu_data;
        end else if (pop) begin
            if (live_q[rd_ptr_q]) begin
                reg_write_d = 1'b1;
                wreg_d      = rd_q[rd_ptr_q];
                wdata_d     = data_q[rd_ptr_q];
            end
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        // Push after the squash so a reused slot always starts live.
        if (push) begin
            live_d[wr_ptr_q] = 1'b1;
            rd_d[wr_ptr_q]   = lsu_rd;
            data_d[wr_ptr_q] = lsu_data;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (pop || empty)
            starve_d = '0;
        else if (alu_wr)
            starve_d = starve_q + SW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            starve_q    <= '0;
            reg_write_q <= 1'b0;
            wreg_q      <= '0;
            wdata_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            live_q      <= live_d;
            rd_q        <= rd_d;
            data_q      <= data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            reg_write_q <= reg_write_d;
            wreg_q      <= wreg_d;
            wdata_q     <= wdata_d;
        end
    end

    assign RegWrite      = reg_write_q;
    assign WriteRegister = wreg_q;
    assign WriteData     = wdata_q;
    assign buf_count     = count_q;

`ifdef WB_PEND_LOOKUP_EN
    logic [PW-1:0] idx;

    // Scan oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        pend_hit  = 1'b0;
        pend_data = '0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if ((CW'(i) < count_q) && live_q[idx] && (rd_q[idx] == pend_query_rd) &&
                (pend_query_rd != 5'd0)) begin
                pend_hit  = 1'b1;
                pend_data = data_q[idx];
            end
        end
    end
`else
    logic unused_query;
    assign unused_query = ^pend_query_rd;
    assign pend_hit     = 1'b0;
    assign pend_data    = '0;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Randomized and directed bench for wb_write_arbiter against a queue-based writeback model.
module tb_wb_write_arbiter;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, lsu_valid;
    logic [4:0]  alu_rd, lsu_rd, pend_query_rd;
    logic [31:0] alu_data, lsu_data;
    logic        alu_hold, lsu_ready, RegWrite, pend_hit;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData, pend_data;
    logic [$clog2(DEPTH+1)-1:0] buf_count;

    wb_write_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_hold(alu_hold),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .buf_count(buf_count), .pend_query_rd(pend_query_rd),
        .pend_hit(pend_hit), .pend_data(pend_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        live;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    int          m_starve;
    logic        m_rw;
    logic [4:0]  m_wr;
    logic [31:0] m_wd;
    logic        m_last_hold;
    int          n_chk = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_starve    = 0;
        m_rw        = 1'b0;
        m_wr        = '0;
        m_wd        = '0;
        m_last_hold = 1'b0;
    endtask

    task automatic zero_inputs();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        pend_query_rd = 0;
    endtask

    // One clock: drive at negedge, check combinational outputs, advance model, check write port.
    task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                        input logic [4:0] q);
        logic        e_hold, e_ready, alu_w, lsu_acc, was_empty, popped, e_hit;
        logic [31:0] e_pd;
        ent_t        e;
        @(negedge clk);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
        pend_query_rd = q;
        #1;
        e_hold  = (m_starve == STARVE_MAX) && (mq.size() != 0);
        e_ready = (mq.size() != DEPTH);
        e_hit   = 1'b0;
        e_pd    = '0;
`ifdef WB_PEND_LOOKUP_EN
        foreach (mq[i]) if (mq[i].live && mq[i].rd == q && q != 0) begin
            e_hit = 1'b1;
            e_pd  = mq[i].data;
        end
`endif
        chk("alu_hold", 32'(alu_hold), 32'(e_hold));
        chk("lsu_ready", 32'(lsu_ready), 32'(e_ready));
        chk("buf_count", 32'(buf_count), 32'(mq.size()));
        chk("pend_hit", 32'(pend_hit), 32'(e_hit));
        chk("pend_data", pend_data, e_pd);

        alu_w     = av && !e_hold && ard != 0;
        lsu_acc   = lv && e_ready;
        was_empty = (mq.size() == 0);
        popped    = 1'b0;
        m_rw      = 1'b0;
        if (alu_w) begin
            foreach (mq[i]) if (mq[i].rd == ard) mq[i].live = 1'b0;
            m_rw = 1'b1; m_wr = ard; m_wd = ad;
        end else if (!was_empty) begin
            e = mq.pop_front();
            popped = 1'b1;
            if (e.live) begin
                m_rw = 1'b1; m_wr = e.rd; m_wd = e.data;
            end
        end
        if (lsu_acc && lrd != 0 && !(alu_w && lrd == ard)) begin
            e.live = 1'b1; e.rd = lrd; e.data = ld;
            mq.push_back(e);
        end
        if (popped || was_empty) m_starve = 0;
        else if (alu_w)          m_starve = m_starve + 1;
        m_last_hold = av && e_hold;

        @(posedge clk);
        #1;
        chk("RegWrite", 32'(RegWrite), 32'(m_rw));
        chk("WriteRegister", 32'(WriteRegister), 32'(m_wr));
        chk("WriteData", WriteData, m_wd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic        av, lv;
        logic [4:0]  ard, lrd;
        logic [31:0] ad, ld;
        int          nxt;

        zero_inputs();
        rst = 1'b1;
        model_clear();
        #1;
        chk("rst_RegWrite", 32'(RegWrite), 0);
        chk("rst_WriteRegister", 32'(WriteRegister), 0);
        chk("rst_WriteData", WriteData, 0);
        chk("rst_buf_count", 32'(buf_count), 0);
        chk("rst_lsu_ready", 32'(lsu_ready), 1);
        chk("rst_alu_hold", 32'(alu_hold), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single ALU write.
        step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
        chk("alu_wd_const", WriteData, 32'hDEADBEEF);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("alu_idle_const", 32'(RegWrite), 0);

        // LSU fill under ALU contention, including a request against a full buffer.
        step(1, 10, 32'h1, 1, 3, 32'h11, 0);
        step(1, 10, 32'h2, 1, 4, 32'h22, 0);
        step(1, 10, 32'h3, 1, 6, 32'h33, 0);
        step(1, 11, 32'h4, 1, 7, 32'h44, 0);
        step(1, 11, 32'h5, 1, 8, 32'h55, 0);
        step(1, 11, 32'h6, 1, 9, 32'h66, 0);
        idle(6);

        // Buffered write squashed by a younger ALU write to the same rd.
        step(0, 0, 0, 1, 9, 32'hAA, 0);
        step(1, 9, 32'hBB, 0, 0, 0, 0);
        chk("squash_wd_const", WriteData, 32'hBB);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("squash_silent_const", 32'(RegWrite), 0);
        chk("squash_empty_const", 32'(buf_count), 0);
        idle(1);

        // Starvation bound: continuous ALU traffic with one buffered entry.
        nxt = 1;
        step(1, 5'(nxt), 32'h100, 1, 2, 32'h55, 0);
        for (int i = 0; i < 6; i++) begin
            if (!m_last_hold) nxt = (nxt == 1) ? 3 : nxt + 1;
            step(1, 5'(nxt), 32'h100 + 32'(nxt), 0, 0, 0, 0);
        end
        idle(2);

        // Pending lookup with two entries to the same rd.
        step(1, 11, 32'h7, 1, 8, 32'h1, 0);
        step(1, 12, 32'h8, 1, 8, 32'h2, 0);
        step(1, 13, 32'h9, 0, 0, 0, 8);
        step(1, 14, 32'hA, 0, 0, 0, 0);
        idle(3);

        // Asynchronous reset mid-cycle with three entries buffered.
        step(1, 1, 32'h10, 1, 20, 32'hA0, 0);
        step(1, 1, 32'h11, 1, 21, 32'hA1, 0);
        step(1, 1, 32'h12, 1, 22, 32'hA2, 0);
        chk("pre_rst_count_const", 32'(buf_count), 3);
        @(negedge clk);
        zero_inputs();
        #2 rst = 1'b1;
        #1;
        chk("arst_RegWrite", 32'(RegWrite), 0);
        chk("arst_buf_count", 32'(buf_count), 0);
        chk("arst_lsu_ready", 32'(lsu_ready), 1);
        chk("arst_alu_hold", 32'(alu_hold), 0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(4);

        // Random traffic; held ALU and refused LSU requests are re-presented.
        av = 0; ard = 0; ad = 0; lv = 0; lrd = 0; ld = 0;
        for (int i = 0; i < 600; i++) begin
            if (!m_last_hold) begin
                av  = ($urandom_range(0, 99) < 55);
                ard = 5'($urandom_range(0, 7));
                ad  = $urandom;
            end
            if (!(lv && mq.size() == DEPTH) || $urandom_range(0, 3) == 0) begin
                lv  = ($urandom_range(0, 99) < 60);
                lrd = 5'($urandom_range(0, 7));
                ld  = $urandom;
            end
            step(av, ard, ad, lv, lrd, ld, 5'($urandom_range(0, 7)));
        end
        idle(6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
